// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR MAC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   TAPS, DATA_W, COEF_W, ACC_W, COEF_FRAC : default filter geometry
//   DRAIN_CYC                              : pipeline drain length after the last tap
//   state_t                                : sequencer state encoding
package fir_pkg;

  localparam int TAPS      = 32;  // number of taps
  localparam int DATA_W    = 16;  // Q1.15 samples
  localparam int COEF_W    = 16;  // Q1.15 coefficients
  localparam int ACC_W     = 40;  // >= DATA_W + COEF_W + $clog2(TAPS)
  localparam int COEF_FRAC = 15;  // fractional coefficient bits dropped at output

  // Two cycles to flush ROM read and product register, one to settle the sum.
  localparam int DRAIN_CYC = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, drop COEF_FRAC bits and saturate an accumulator to DATA_W.
// Latency: purely combinational.
// Backpressure: none; output follows input.
//
// Ports:
//   acc : in  signed ACC_W   full-precision accumulator value
//   y   : out signed DATA_W  rounded and saturated sample
module fir_round_sat #(
  parameter int ACC_W     = 40,
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 15
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  // One guard bit so the rounding constant can never wrap the sum.
  localparam int SUM_W = ACC_W + 1;
  // Width of the value after the fractional bits are removed.
  localparam int R_W   = SUM_W - COEF_FRAC;

  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (COEF_FRAC - 1);

  logic signed [SUM_W-1:0] sum;
  logic signed [R_W-1:0]   r;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic                    unused_frac;

  always_comb begin
    sum = {acc[ACC_W-1], acc} + HALF;
    // Taking the upper bits of a two's complement value is a floor shift,
    // which together with +HALF gives round-half-up.
    r   = sum[SUM_W-1:COEF_FRAC];

    // Out of range when the bits above the output sign disagree with the sign.
    pos_ovf = !r[R_W-1] &&  (|r[R_W-2:DATA_W-1]);
    neg_ovf =  r[R_W-1] && !(&r[R_W-2:DATA_W-1]);

    y = r[DATA_W-1:0];
    if (pos_ovf) begin
      y = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (neg_ovf) begin
      y = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  // Fraction bits only matter through the rounding carry.
  assign unused_frac = ^sum[COEF_FRAC-1:0];

endmodule

// File: rtl/fir_mac_seq.sv
// MAC sequencer: on start, sweeps taps 0..TAPS-1, accumulates tap*coef, emits one rounded sample.
// Latency: start accepted at end of cycle 0, y_valid pulse in cycle TAPS+4.
// Backpressure: none; start while busy is dropped and flagged on sticky overrun.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : in  new sample available, begin a computation (accepted only when idle)
//   abort      : in  cancel a running computation; dominates start
//   adres      : out tap/coef address for shift register and coefficient ROM
//   tap_data   : in  registered shift-register read of adres (1 cycle)
//   coef_data  : in  registered coefficient ROM read of adres (1 cycle)
//   y_out      : out filtered sample, held until the next result
//   y_valid    : out 1-cycle pulse when y_out is updated
//   busy       : out computation in progress
//   overrun    : out sticky, start seen while busy; cleared only by reset
module fir_mac_seq #(
  parameter  int TAPS      = fir_pkg::TAPS,
  parameter  int DATA_W    = fir_pkg::DATA_W,
  parameter  int COEF_W    = fir_pkg::COEF_W,
  parameter  int ACC_W     = fir_pkg::ACC_W,
  parameter  int COEF_FRAC = fir_pkg::COEF_FRAC,
  localparam int AW        = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic [AW-1:0]            adres,
  input  logic signed [DATA_W-1:0] tap_data,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  import fir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;

  state_t state_q;
  state_t state_d;

  logic [1:0]               drain_cnt_q;
  logic                     rd_vld_q;    // operands for some tap present on tap/coef inputs
  logic                     acc_vld_q;   // product register holds a product to be summed
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] y_rnd;

  logic last_tap;
  logic last_drain;
  logic accept;
  logic kill;
  logic done;

  assign busy       = (state_q != IDLE);
  assign last_tap   = (adres == AW'(TAPS - 1));
  assign last_drain = (drain_cnt_q == 2'(DRAIN_CYC - 1));
  // abort dominates start in every state, so a simultaneous start is simply dropped.
  assign accept     = (state_q == IDLE) && start && !abort;
  assign kill       = busy && abort;
  assign done       = (state_q == DRAIN) && last_drain && !abort;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_tap) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || last_drain) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address and drain counters
  // ---------------------------------------------------------------------------
  // adres is 0 everywhere except while stepping through ISSUE, so the first
  // ISSUE cycle already presents tap 0 without a separate load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adres       <= '0;
      drain_cnt_q <= '0;
    end else begin
      if ((state_q == ISSUE) && !abort && !last_tap) begin
        adres <= adres + 1'b1;
      end else begin
        adres <= '0;
      end

      if ((state_q == DRAIN) && !abort && !last_drain) begin
        drain_cnt_q <= drain_cnt_q + 1'b1;
      end else begin
        drain_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MAC pipeline: address -> registered read -> product reg -> accumulator
  // ---------------------------------------------------------------------------
  // rd_vld_q lines up with the cycle the ROM/shift register output is valid,
  // acc_vld_q with the cycle the product register holds that tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      acc_vld_q <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
    end else begin
      rd_vld_q  <= (state_q == ISSUE) && !abort;
      acc_vld_q <= rd_vld_q && !kill;

      if (rd_vld_q) begin
        prod_q <= tap_data * coef_data;
      end

      // Sizing guarantees no overflow, so the sum is never clamped here.
      if (accept || kill) begin
        acc_q <= '0;
      end else if (acc_vld_q) begin
        acc_q <= acc_q + {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  fir_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_round_sat (
    .acc (acc_q),
    .y   (y_rnd)
  );

  // The last product lands in the accumulator at the end of the second DRAIN
  // cycle, so the final DRAIN cycle samples a complete sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= done;
      if (done) begin
        y_out <= y_rnd;
      end
      if (start && busy && !abort) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Testbench for fir_mac_seq with a registered tap/coef memory model and a result scoreboard.
module tb_fir_mac_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  adres;
  logic [15:0] tap_data  = '0;
  logic [15:0] coef_data = '0;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  logic [15:0] tap_mem  [32];
  logic [15:0] coef_mem [32];

  typedef struct {
    logic [15:0] y;
    longint      cyc;
  } exp_t;

  exp_t        sbq[$];
  longint      cyc      = 0;
  int          total    = 0;
  int          bad      = 0;
  logic [15:0] last_exp = 16'h0000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shift register and coefficient ROM: one-cycle registered read of adres.
  always @(posedge clk) begin
    tap_data  <= tap_mem[adres];
    coef_data <= coef_mem[adres];
  end

  fir_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .adres     (adres),
    .tap_data  (tap_data),
    .coef_data (coef_data),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: exact dot product, round half up, saturate to Q1.15.
  function automatic logic [15:0] model_y();
    longint s = 0;
    longint r;
    for (int k = 0; k < 32; k++) begin
      s += longint'($signed(tap_mem[k])) * longint'($signed(coef_mem[k]));
    end
    r = (s + 64'sd16384) >>> 15;
    if (r > 64'sd32767)       r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
    return r[15:0];
  endfunction

  task automatic load_single(input logic [15:0] t, input logic [15:0] c);
    for (int k = 0; k < 32; k++) begin
      tap_mem[k]  = 16'h0000;
      coef_mem[k] = 16'h0000;
    end
    tap_mem[0]  = t;
    coef_mem[0] = c;
  endtask

  task automatic load_all(input logic [15:0] t, input logic [15:0] c);
    for (int k = 0; k < 32; k++) begin
      tap_mem[k]  = t;
      coef_mem[k] = c;
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic kick();
    exp_t e;
    e.y   = model_y();
    e.cyc = cyc + 36;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_one();
    kick();
    repeat (37) @(negedge clk);
  endtask

  // Scoreboard consumer: every y_valid must match the oldest outstanding job.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && y_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", y_valid, 1'b0);
      end else begin
        e = sbq.pop_front();
        last_exp = e.y;
        chk("y_out", y_out, e.y);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    load_all(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_adres",   adres,   0);
    chk("rst_y_out",   y_out,   0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single tap with address sweep and busy/valid timing
    load_single(16'h4000, 16'h4000);
    kick();
    for (int i = 0; i < 32; i++) begin
      chk("adres_sweep", adres, i);
      chk("busy_issue", busy, 1);
      @(negedge clk);
    end
    chk("adres_drain", adres, 0);
    chk("busy_c33", busy, 1);
    repeat (2) @(negedge clk);
    chk("busy_c35", busy, 1);
    chk("valid_c35", y_valid, 0);
    @(negedge clk);
    chk("busy_c36", busy, 0);
    chk("valid_c36", y_valid, 1);
    chk("adres_c36", adres, 0);
    repeat (2) @(negedge clk);

    // Saturation and rounding
    load_all(16'h4000, 16'h4000);    run_one();
    load_all(16'h8000, 16'h7FFF);    run_one();
    load_single(16'h0001, 16'h4000); run_one();
    load_single(16'hFFFF, 16'h4000); run_one();
    load_single(16'h1234, 16'hC000); run_one();

    // Back-to-back start in the y_valid cycle
    load_single(16'h4000, 16'h4000);
    kick();
    repeat (35) @(negedge clk);
    chk("b2b_valid_c36", y_valid, 1);
    load_single(16'h0001, 16'h4000);
    kick();
    chk("b2b_busy", busy, 1);
    repeat (37) @(negedge clk);

    // Abort in cycle 20
    load_all(16'h0100, 16'h0100);
    kick();
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(sbq.pop_back());
    chk("abort_busy", busy, 0);
    chk("abort_adres", adres, 0);
    repeat (40) @(negedge clk);
    chk("abort_y_hold", y_out, last_exp);

    // Abort and start together while busy: abort wins, no overrun
    load_all(16'h0100, 16'h0100);
    kick();
    repeat (4) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    void'(sbq.pop_back());
    chk("abst_busy", busy, 0);
    chk("abst_overrun", overrun, 0);
    repeat (40) @(negedge clk);
    chk("abst_y_hold", y_out, last_exp);

    // start in cycle 10: overrun, result unaffected
    load_single(16'h4000, 16'h4000);
    kick();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy", busy, 1);
    repeat (28) @(negedge clk);
    chk("ovr_sticky", overrun, 1);

    // Async reset in cycle 15, then a fresh run
    load_all(16'h0100, 16'h0100);
    kick();
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    void'(sbq.pop_back());
    #1;
    chk("mid_rst_adres",   adres,   0);
    chk("mid_rst_y_out",   y_out,   0);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_busy",    busy,    0);
    chk("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    load_single(16'h4000, 16'h4000);
    run_one();

    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
